// File: rtl/sfence_vma_ctrl.sv
// SFENCE.VMA controller: captures rs1/rs2 at issue, waits for commit and
// for the store path to drain, then drives a FLUSH_CYCLES-long TLB flush.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             pipeline flush, kills an uncommitted SFENCE.VMA
//   valid_i / ready_o   issue handshake, operands rs1_i/rs2_i + x0 flags
//   commit_i            captured instruction commits
//   no_st_pending_i     store and write buffers are empty
//   flush_tlb_o         TLB flush request, with vaddr/asid/all-flags
//   busy_o, done_o      not idle / one-cycle completion pulse
module sfence_vma_ctrl #(
    parameter int unsigned ASID_WIDTH   = 1,
    parameter int unsigned VLEN         = 39,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [VLEN-1:0]       rs1_i,
    input  logic [ASID_WIDTH-1:0] rs2_i,
    input  logic                  rs1_is_x0_i,
    input  logic                  rs2_is_x0_i,
    output logic                  ready_o,
    input  logic                  commit_i,
    input  logic                  no_st_pending_i,
    output logic                  flush_tlb_o,
    output logic [VLEN-1:0]       flush_vaddr_o,
    output logic [ASID_WIDTH-1:0] flush_asid_o,
    output logic                  flush_all_vaddr_o,
    output logic                  flush_all_asid_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_COMMIT,
        DRAIN,
        FLUSH,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [VLEN-1:0]       vaddr_q;
    logic [ASID_WIDTH-1:0] asid_q;
    logic                  all_vaddr_q;
    logic                  all_asid_q;

    logic capture;
    logic kill;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        capture     = 1'b0;
        kill        = 1'b0;
        ready_o     = 1'b0;
        flush_tlb_o = 1'b0;
        done_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i && !flush_i) begin
                    capture = 1'b1;
                    state_d = WAIT_COMMIT;
                end
            end
            WAIT_COMMIT: begin
                // A kill wins over a same-cycle commit.
                if (flush_i) begin
                    kill    = 1'b1;
                    state_d = IDLE;
                end else if (commit_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Committed: pipeline flushes no longer apply.
                if (no_st_pending_i) begin
                    cnt_d   = CNT_LOAD;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                flush_tlb_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            vaddr_q     <= '0;
            asid_q      <= '0;
            all_vaddr_q <= 1'b0;
            all_asid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                vaddr_q     <= rs1_i;
                asid_q      <= rs2_i;
                all_vaddr_q <= rs1_is_x0_i;
                all_asid_q  <= rs2_is_x0_i;
            end else if (kill) begin
                all_vaddr_q <= 1'b0;
                all_asid_q  <= 1'b0;
            end
        end
    end

    assign flush_vaddr_o     = vaddr_q;
    assign flush_asid_o      = asid_q;
    assign flush_all_vaddr_o = all_vaddr_q;
    assign flush_all_asid_o  = all_asid_q;
    assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_sfence_vma_ctrl.sv
// Directed bench for sfence_vma_ctrl: two instances, FLUSH_CYCLES 2 and 4.
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_sfence_vma_ctrl;

    localparam int AW = 1;
    localparam int VL = 39;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic valid;
    logic valid4;
    logic [VL-1:0] rs1;
    logic [AW-1:0] rs2;
    logic rs1_x0;
    logic rs2_x0;
    logic commit;
    logic no_st;

    logic ready, tlb, all_va, all_as, busy, done;
    logic [VL-1:0] va;
    logic [AW-1:0] as;

    logic ready4, tlb4, all_va4, all_as4, busy4, done4;
    logic [VL-1:0] va4;
    logic [AW-1:0] as4;

    int passed = 0;
    int total  = 0;
    int n;

    always #5 clk = ~clk;

    sfence_vma_ctrl #(
        .ASID_WIDTH(AW), .VLEN(VL), .FLUSH_CYCLES(2)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .valid_i(valid), .rs1_i(rs1), .rs2_i(rs2),
        .rs1_is_x0_i(rs1_x0), .rs2_is_x0_i(rs2_x0),
        .ready_o(ready), .commit_i(commit),
        .no_st_pending_i(no_st), .flush_tlb_o(tlb),
        .flush_vaddr_o(va), .flush_asid_o(as),
        .flush_all_vaddr_o(all_va),
        .flush_all_asid_o(all_as),
        .busy_o(busy), .done_o(done)
    );

    sfence_vma_ctrl #(
        .ASID_WIDTH(AW), .VLEN(VL), .FLUSH_CYCLES(4)
    ) u_dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .valid_i(valid4), .rs1_i(rs1), .rs2_i(rs2),
        .rs1_is_x0_i(rs1_x0), .rs2_is_x0_i(rs2_x0),
        .ready_o(ready4), .commit_i(commit),
        .no_st_pending_i(no_st), .flush_tlb_o(tlb4),
        .flush_vaddr_o(va4), .flush_asid_o(as4),
        .flush_all_vaddr_o(all_va4),
        .flush_all_asid_o(all_as4),
        .busy_o(busy4), .done_o(done4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h",
                    tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; valid = 1'b0; valid4 = 1'b0;
        rs1 = '0; rs2 = '0; rs1_x0 = 1'b0; rs2_x0 = 1'b0;
        commit = 1'b0; no_st = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // reset state
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tlb", 64'(tlb), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_vaddr", 64'(va), 64'd0);
        chk("rst_asid", 64'(as), 64'd0);
        chk("rst_allva", 64'(all_va), 64'd0);
        chk("rst_allas", 64'(all_as), 64'd0);

        // basic: issue at cycle 0
        valid = 1'b1; rs1 = 39'h40_0000_1000; rs2 = 1'b1;
        tick();                         // +1 WAIT_COMMIT
        valid = 1'b0; rs1 = 39'h7f_ffff_ffff; rs2 = 1'b0;
        chk("b_ready1", 64'(ready), 64'd0);
        chk("b_busy1", 64'(busy), 64'd1);
        chk("b_tlb1", 64'(tlb), 64'd0);
        commit = 1'b1;
        tick();                         // +2 DRAIN
        commit = 1'b0;
        chk("b_tlb2", 64'(tlb), 64'd0);
        tick();                         // +3 FLUSH
        chk("b_tlb3", 64'(tlb), 64'd1);
        chk("b_va3", 64'(va), 64'h40_0000_1000);
        chk("b_as3", 64'(as), 64'd1);
        tick();                         // +4 FLUSH
        chk("b_tlb4", 64'(tlb), 64'd1);
        chk("b_va4", 64'(va), 64'h40_0000_1000);
        tick();                         // +5 DONE
        chk("b_tlb5", 64'(tlb), 64'd0);
        chk("b_done5", 64'(done), 64'd1);
        chk("b_ready5", 64'(ready), 64'd0);
        tick();                         // +6 IDLE
        chk("b_ready6", 64'(ready), 64'd1);
        chk("b_done6", 64'(done), 64'd0);

        // kill: flush with commit at +1
        valid = 1'b1; rs1 = 39'h12_3456_7000; rs2 = 1'b0;
        rs1_x0 = 1'b1;
        tick();
        valid = 1'b0; rs1_x0 = 1'b0;
        chk("k_allva1", 64'(all_va), 64'd1);
        flush = 1'b1; commit = 1'b1;
        tick();                         // +2
        flush = 1'b0; commit = 1'b0;
        chk("k_ready2", 64'(ready), 64'd1);
        chk("k_allva2", 64'(all_va), 64'd0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (tlb || done) n++;
            tick();
        end
        chk("k_no_flush", 64'(n), 64'd0);

        // drain stall, flush_i during DRAIN ignored
        valid = 1'b1; rs1 = 39'h00_0000_2000; rs2 = 1'b1;
        tick();
        valid = 1'b0; commit = 1'b1; no_st = 1'b0;
        tick();                         // DRAIN
        commit = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            flush = (i == 4);
            if (tlb) n++;
            tick();
        end
        flush = 1'b0;
        chk("d_stall", 64'(n), 64'd0);
        chk("d_busy", 64'(busy), 64'd1);
        chk("d_tlb_pre", 64'(tlb), 64'd0);
        no_st = 1'b1;
        tick();
        chk("d_tlb", 64'(tlb), 64'd1);
        chk("d_va", 64'(va), 64'h00_0000_2000);
        tick(); tick();
        chk("d_done", 64'(done), 64'd1);
        tick();

        // global flush
        valid = 1'b1; rs1 = '0; rs2 = '0;
        rs1_x0 = 1'b1; rs2_x0 = 1'b1;
        tick();
        valid = 1'b0; rs1_x0 = 1'b0; rs2_x0 = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        chk("g_tlb1", 64'(tlb), 64'd1);
        chk("g_flags1", 64'({all_va, all_as}), 64'd3);
        tick();
        chk("g_tlb2", 64'(tlb), 64'd1);
        chk("g_flags2", 64'({all_va, all_as}), 64'd3);
        tick();
        chk("g_done", 64'(done), 64'd1);
        tick();

        // back-to-back with valid held high
        valid = 1'b1; rs1 = 39'h00_0000_a000; rs2 = 1'b0;
        tick();                         // WAIT_COMMIT
        rs1 = 39'h00_0000_b000;
        tick();                         // still waiting
        chk("bb_hold", 64'(va), 64'h00_0000_a000);
        rs1 = 39'h00_0000_c000;
        commit = 1'b1;
        tick();                         // DRAIN
        commit = 1'b0;
        rs1 = 39'h00_0000_d000;
        tick(); tick();                 // FLUSH x2
        chk("bb_va", 64'(va), 64'h00_0000_a000);
        rs1 = 39'h00_0000_e000;
        tick();                         // DONE
        chk("bb_done", 64'(done), 64'd1);
        chk("bb_va_done", 64'(va), 64'h00_0000_a000);
        tick();                         // IDLE
        chk("bb_ready", 64'(ready), 64'd1);
        rs1 = 39'h00_0000_f000;
        tick();                         // second accepted
        valid = 1'b0;
        chk("bb_busy2", 64'(busy), 64'd1);
        chk("bb_va2", 64'(va), 64'h00_0000_f000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("bb_idle", 64'(ready), 64'd1);

        // FLUSH_CYCLES=4 full run
        valid4 = 1'b1; rs1 = 39'h01_0000_0000; rs2 = 1'b1;
        tick();
        valid4 = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (tlb4) n++;
            tick();
        end
        chk("f4_len", 64'(n), 64'd4);
        chk("f4_idle", 64'(ready4), 64'd1);

        // reset on second flush cycle
        valid4 = 1'b1; rs1 = 39'h02_0000_0000; rs2 = 1'b1;
        rs1_x0 = 1'b1;
        tick();
        valid4 = 1'b0; rs1_x0 = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();                         // flush cycle 1
        chk("r_tlb1", 64'(tlb4), 64'd1);
        tick();                         // flush cycle 2
        chk("r_tlb2", 64'(tlb4), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_tlb", 64'(tlb4), 64'd0);
        chk("r_ready", 64'(ready4), 64'd1);
        chk("r_busy", 64'(busy4), 64'd0);
        chk("r_done", 64'(done4), 64'd0);
        chk("r_va", 64'(va4), 64'd0);
        chk("r_as", 64'(as4), 64'd0);
        chk("r_allva", 64'(all_va4), 64'd0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (tlb4 || done4) n++;
            tick();
        end
        chk("r_quiet", 64'(n), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
